// File: rtl/itcm_ctrl_pkg.sv
// Shared ITCM sizing constants and small types used by the controller and its buffer.
package itcm_ctrl_pkg;

  localparam int unsigned ITCM_ADDR_WIDTH = 16;
  localparam int unsigned ITCM_RAM_DW     = 32;
  localparam int unsigned ITCM_RAM_AW     = ITCM_ADDR_WIDTH - 2;
  localparam int unsigned PC_SIZE         = 32;

  // Occupancy of the 2-entry response buffer (0..2).
  typedef logic [1:0] cnt_t;

  localparam cnt_t RSP_DEPTH = 2'd2;

endpackage

// File: rtl/itcm_ctrl_if.sv
// IFU-to-ITCM fetch port: command channel plus valid/ready response channel.
interface itcm_ctrl_if import itcm_ctrl_pkg::*; #(
  parameter int unsigned ADDR_W = ITCM_ADDR_WIDTH,
  parameter int unsigned DW     = ITCM_RAM_DW
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/itcm_rsp_fifo.sv
// 2-entry response buffer with wrapping 1-bit pointers and an occupancy count.
module itcm_rsp_fifo import itcm_ctrl_pkg::*; #(
  parameter int unsigned DW = ITCM_RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output cnt_t          cnt
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q, rptr_q;
  cnt_t          cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  assign head = mem_q[rptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/itcm_ctrl.sv
// Instruction-side ITCM controller: single-cycle SRAM reads with a 2-entry bypassable
// response buffer and credit-based command flow control.
module itcm_ctrl import itcm_ctrl_pkg::*; #(
  parameter int unsigned ADDR_W = ITCM_ADDR_WIDTH,
  parameter int unsigned DW     = ITCM_RAM_DW,
  parameter int unsigned RAM_AW = ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  itcm_ctrl_if.slave        ifu2itcm,
  output logic              itcm_ram_cs,
  output logic [RAM_AW-1:0] itcm_ram_addr,
  input  logic [DW-1:0]     itcm_ram_dout
);

  logic          acc;
  logic          pend_q;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [DW-1:0] fifo_head;
  cnt_t          fifo_cnt;
  logic [1:0]    unused_addr_lsb;

  assign unused_addr_lsb = ifu2itcm.cmd_addr[1:0];

  // Credits count both buffered words and the read in flight, so the buffer cannot overflow
  // and the response channel never feeds back into cmd_ready combinationally.
  assign ifu2itcm.cmd_ready = ~rst & ((fifo_cnt + cnt_t'(pend_q)) < RSP_DEPTH);

  assign acc           = ifu2itcm.cmd_valid & ifu2itcm.cmd_ready;
  assign itcm_ram_cs   = acc;
  assign itcm_ram_addr = RAM_AW'(ifu2itcm.cmd_addr[ADDR_W-1:2]);

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= acc;
  end

  assign fifo_empty         = (fifo_cnt == '0);
  assign ifu2itcm.rsp_valid = ~rst & (~fifo_empty | pend_q);
  assign ifu2itcm.rsp_rdata = fifo_empty ? itcm_ram_dout : fifo_head;

  assign pop       = ifu2itcm.rsp_valid & ifu2itcm.rsp_ready;
  assign fifo_push = pend_q & ~(fifo_empty & pop);
  assign fifo_pop  = pop & ~fifo_empty;

  itcm_rsp_fifo #(
    .DW (DW)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (itcm_ram_dout),
    .pop  (fifo_pop),
    .head (fifo_head),
    .cnt  (fifo_cnt)
  );

endmodule

// File: doc/itcm_ctrl.md
# itcm_ctrl

- Instruction-side ITCM controller; sits directly downstream of the IFU fetch port (`ifu2itcm_*`).
- Accepts fetch commands, issues single-cycle-latency SRAM reads and returns instruction words on a valid/ready response channel.
- A 2-entry response buffer with bypass sustains one fetch per cycle and absorbs IFU back-pressure without losing SRAM data.

## Interface

**Parameters**

- `ADDR_W`, default `` `ITCM_ADDR_WIDTH `` (16): byte address width of the fetch command.
- `DW`, default `` `ITCM_RAM_DW `` (32): SRAM word and response data width.
- `RAM_AW`, default `ADDR_W-2`: SRAM word-address width.

**Ports**

- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `ifu2itcm_cmd_valid` in 1: fetch request valid.
- `ifu2itcm_cmd_ready` out 1: request accepted when high together with valid.
- `ifu2itcm_cmd_addr` in ADDR_W: byte address; bits [1:0] ignored.
- `ifu2itcm_rsp_valid` out 1: instruction word available.
- `ifu2itcm_rsp_ready` in 1: IFU consumes the response.
- `ifu2itcm_rsp_rdata` out DW: instruction word.
- `itcm_ram_cs` out 1: SRAM read enable.
- `itcm_ram_addr` out RAM_AW: SRAM word address.
- `itcm_ram_dout` in DW: SRAM read data, valid the cycle after `cs`.

## Operation

- **Accept.** `acc = cmd_valid & cmd_ready`. On `acc`:
  - `itcm_ram_cs = 1` in the same cycle (combinational).
  - `itcm_ram_addr = cmd_addr[ADDR_W-1:2]`.
- **Pending flag.** `pend` is a register set to `acc` every cycle. It marks SRAM data present on `itcm_ram_dout` this cycle.
- **Buffer.** 2-entry FIFO with occupancy counter `cnt` (0..2) and 1-bit read/write pointers that wrap.
- **Response.**
  - `rsp_valid = (cnt != 0) | pend`.
  - `rsp_rdata = (cnt != 0) ? FIFO head : itcm_ram_dout`. The bypass is used only when the FIFO is empty.
- **Per-cycle update**, with `pop = rsp_valid & rsp_ready`:
  - `pend & (cnt==0) & pop`: data bypassed, FIFO unchanged.
  - `pend & !(cnt==0 & pop)`: `itcm_ram_dout` pushed to the FIFO tail.
  - `pop & cnt!=0`: head popped.
  - Push and pop may happen in the same cycle; `cnt` is then unchanged.
- **Credit rule.** `cmd_ready = !rst & ((cnt + pend) < 2)`.
  - It does not depend on `rsp_ready`, so there is no combinational path from the response channel to the command channel.
  - This guarantees the FIFO never overflows: at most 2 words are owed to the IFU.
- **Ordering.** Strictly in order; responses are returned in command acceptance order.
- **Data rules.** `itcm_ram_dout` is sampled only in a `pend` cycle. SRAM outputs in other cycles are don't-care.

## Timing

- **Latency.** A command accepted in cycle N gives `rsp_valid` in cycle N+1 when the FIFO is empty (bypass).
- **Throughput.** With `rsp_ready` held high: one command and one response per cycle, with `cnt` staying 0.
- **Stall.** `rsp_ready` low with a continuous command stream:
  - The FIFO fills.
  - `cmd_ready` drops once `cnt + pend == 2`.
  - At most 2 commands are accepted after the stall begins, counting the one already pending.
- **Resume.** The first `pop` after a stall frees a credit. `cmd_ready` rises the cycle after that pop.
- **Stability.** While `rsp_valid & !rsp_ready`, `rsp_rdata` holds stable: the head stays fixed, and bypass data is captured into the FIFO.
- **Reset values (rst high):**
  - `cnt=0`, `pend=0`, pointers 0.
  - `cmd_ready=0`, `rsp_valid=0`, `itcm_ram_cs=0`, `itcm_ram_addr` don't-care.
- **Reset mid-operation.** Buffered words and in-flight SRAM data are discarded. No response is emitted in the cycle after reset deasserts.
- **Command during reset.** `cmd_valid` while `rst` is high is not accepted.

## Structure

- **Shared package (`defines.v`):** `` `ITCM_ADDR_WIDTH ``, `` `ITCM_RAM_DW ``, `` `ITCM_RAM_AW ``, `` `PC_SIZE ``.
- **Sub-module `itcm_rsp_fifo`:** 2-entry, DW wide, with `push`/`pop`, `head`, `cnt`, and synchronous active-high `rst`.
- **`itcm_ctrl` owns:** the `pend` flag, the credit logic, the bypass mux and the SRAM drive.

## Test plan

- **Single fetch.** `cmd addr=0x0010` in cycle 0, `rsp_ready=1`:
  - cycle 0: `ram_cs=1`, `ram_addr=0x004`.
  - cycle 1: `rsp_valid=1`, `rdata = mem[4]`.
- **Streaming.** Addresses 0x0000, 0x0004, … 0x003C back-to-back, `rsp_ready=1`:
  - `cmd_ready` never drops.
  - 16 responses in order, `mem[0..15]`, one per cycle, on cycles 1–16.
- **Back-pressure.** Stream from 0x0100 with `rsp_ready=0` from cycle 0:
  - Exactly 2 commands accepted; `cmd_ready=0` from cycle 2.
  - `rsp_rdata = mem[0x40]` held stable.
  - Raise `rsp_ready` at cycle 6: `mem[0x40]` then `mem[0x41]`, then the stream resumes with no loss or duplication.
- **Random stalls.** 1000 commands with random `cmd_valid`/`rsp_ready` (50%):
  - Scoreboard matches every word in order.
  - `cnt` never exceeds 2.
- **Reset mid-operation.** FIFO full (cnt=2, pend=0), assert `rst` for 1 cycle:
  - Next cycle: `rsp_valid=0`, `cmd_ready=1`.
  - A new fetch of 0x0008 returns `mem[2]` one cycle later; no stale word appears.
- **Misaligned address.** `cmd addr=0x0013` → `ram_addr=0x004`, response = `mem[4]`.
